// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU.
// One operation at a time: 32-cycle shift-add multiply or restoring divide,
// with a fast path for divide-by-zero and signed-overflow divides.
module muldiv_sequencer #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ITERATIONS = XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(ITERATIONS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERATIONS - 1);
  localparam logic [XLEN-1:0]  ALL_ONES = '1;
  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_MULHU  = 3'd3;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_DIVU   = 3'd5;
  localparam logic [2:0] F_REM    = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_funct3;
  logic              r_neg1;
  logic              r_neg2;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_result;
  logic              r_busy;
  logic              r_result_valid;

  // Incoming-operation decode: which operands are signed, magnitudes, special cases
  logic              w_is_div_in;
  logic              w_s1_in;
  logic              w_s2_in;
  logic              w_neg1_in;
  logic              w_neg2_in;
  logic [XLEN-1:0]   w_mag1_in;
  logic [XLEN-1:0]   w_mag2_in;
  logic              w_div0_in;
  logic              w_ovf_in;
  logic              w_fast_in;
  logic [XLEN-1:0]   w_fast_result;

  assign w_is_div_in = funct3[2];
  assign w_s1_in     = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                       (funct3 == F_DIV)  || (funct3 == F_REM);
  assign w_s2_in     = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
  assign w_neg1_in   = w_s1_in & data1[XLEN-1];
  assign w_neg2_in   = w_s2_in & data2[XLEN-1];
  assign w_mag1_in   = w_neg1_in ? (~data1 + XLEN'(1)) : data1;
  assign w_mag2_in   = w_neg2_in ? (~data2 + XLEN'(1)) : data2;
  assign w_div0_in   = w_is_div_in && (data2 == '0);
  assign w_ovf_in    = w_is_div_in && !funct3[0] && (data1 == MIN_INT) && (data2 == ALL_ONES);
  assign w_fast_in   = w_div0_in || w_ovf_in;

  // Special results: funct3[1] separates remainder ops from quotient ops
  always_comb begin
    w_fast_result = '0;
    if (w_div0_in) begin
      w_fast_result = funct3[1] ? data1 : ALL_ONES;
    end else if (w_ovf_in) begin
      w_fast_result = funct3[1] ? '0 : MIN_INT;
    end
  end

  // One iteration: hi/lo pair is the product shifter (mul) or remainder/quotient (div)
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_sub;
  logic [XLEN-1:0]   w_hi_nxt;
  logic [XLEN-1:0]   w_lo_nxt;

  assign w_sum       = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_rem_shift = {r_hi, r_lo[XLEN-1]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_b});
  assign w_rem_sub   = w_rem_shift[XLEN-1:0] - r_b;

  always_comb begin
    w_hi_nxt = w_sum[XLEN:1];
    w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
    if (r_funct3[2]) begin
      w_hi_nxt = w_ge ? w_rem_sub : w_rem_shift[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], w_ge};
    end
  end

  // Sign fixup and word select applied on the final iteration
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_final;

  assign w_prod     = {w_hi_nxt, w_lo_nxt};
  assign w_prod_fix = (r_neg1 ^ r_neg2) ? (~w_prod + (2*XLEN)'(1)) : w_prod;
  assign w_quo_fix  = (r_neg1 ^ r_neg2) ? (~w_lo_nxt + XLEN'(1)) : w_lo_nxt;
  assign w_rem_fix  = r_neg1 ? (~w_hi_nxt + XLEN'(1)) : w_hi_nxt;

  always_comb begin
    w_final = w_prod_fix[XLEN-1:0];
    case (r_funct3)
      F_MUL:                     w_final = w_prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:             w_final = w_quo_fix;
      default:                   w_final = w_rem_fix;
    endcase
  end

  // Sequencer FSM with datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_funct3       <= '0;
      r_neg1         <= 1'b0;
      r_neg2         <= 1'b0;
      r_a            <= '0;
      r_b            <= '0;
      r_hi           <= '0;
      r_lo           <= '0;
      r_result       <= '0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
    end else if (flush) begin
      r_state        <= ST_IDLE;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_result_valid <= 1'b0;
          if (start) begin
            r_funct3 <= funct3;
            r_neg1   <= w_neg1_in;
            r_neg2   <= w_neg2_in;
            r_a      <= w_mag1_in;
            r_b      <= w_mag2_in;
            r_hi     <= '0;
            r_lo     <= w_is_div_in ? w_mag1_in : w_mag2_in;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            if (w_fast_in) begin
              r_result       <= w_fast_result;
              r_result_valid <= 1'b1;
              r_state        <= ST_DONE;
            end else begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_result       <= w_final;
            r_result_valid <= 1'b1;
            r_state        <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_result_valid <= 1'b0;
          r_busy         <= 1'b0;
          r_state        <= ST_IDLE;
        end
        default: begin
          r_result_valid <= 1'b0;
          r_busy         <= 1'b0;
          r_state        <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall drops in DONE so EX advances and captures the result on that edge
  assign stall        = start && ((r_state == ST_IDLE) || (r_state == ST_CALC)) && !flush;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign result       = r_result;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit that sits beside the ALU in the execute stage.
- Accepts one M-extension operation at a time from the EX stage and runs a 32-iteration shift-add multiply or restoring divide.
- Holds the pipeline stall until the result is ready.
- Returns a one-cycle result_valid pulse so EX can write the result back.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITERATIONS, XLEN, number of CALC cycles; must equal XLEN.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  EX holds an M-extension instruction; stays high while stalled
- funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- data1  input  32  rs1 operand
- data2  input  32  rs2 operand
- flush  input  1  pipeline kill; aborts any operation in progress
- stall  output  1  freeze IF/ID/EX this cycle
- busy  output  1  state is not IDLE
- result_valid  output  1  result is valid this cycle (DONE state)
- result  output  32  final value; held until the next accepted start

Behaviour:
- Reset: asynchronous and active-low, clearing everything immediately.
  - state=IDLE, counter=0, accumulators=0.
  - result=0, result_valid=0, busy=0.
  - stall=start (combinational), so it is 0 when start=0.
- States: IDLE, CALC, DONE.
- IDLE, start=1, flush=0, at the clock edge:
  - Latch funct3 and sign flags.
  - Latch |data1| and |data2| (magnitude only for signed operands of the op: MULH/DIV/REM both, MULHSU rs1 only).
  - Clear counter and go to CALC.
  - Fast path: if the op is a divide and data2==0, or the op is DIV/REM with data1=0x80000000 and data2=0xFFFFFFFF, go straight to DONE with the special result.
- CALC: one iteration per cycle.
  - Multiply: 64-bit shift-add on unsigned magnitudes.
  - Divide: restoring subtract producing one quotient bit, MSB first.
  - counter increments each cycle; on the edge where counter==ITERATIONS-1, go to DONE.
  - On the same edge, apply sign fixup and load result.
    - Product is negated if the operand signs differ.
    - Quotient is negated if the signs differ.
    - Remainder takes the sign of data1.
    - MUL returns the low word; MULH* return the high word.
- DONE: result_valid=1 for exactly one cycle, then go to IDLE. start is ignored in DONE (same instruction still presented).
- Latency:
  - Normal case: start first high in cycle 0, result_valid in cycle 33.
  - Fast path: result_valid in cycle 1.
- stall = start AND (state==IDLE OR state==CALC) AND NOT flush.
  - Low in DONE, so the pipeline advances on that edge and captures result.
- Special results:
  - Divide by zero: DIV/DIVU quotient=0xFFFFFFFF; REM/REMU=data1.
  - Signed overflow: DIV=0x80000000; REM=0.
- flush has priority over everything except reset.
  - In CALC or DONE, go to IDLE on the next edge, without asserting result_valid afterwards; result keeps its old value.
  - flush together with start in IDLE means the op is not accepted.
- A new start is accepted only in IDLE; back-to-back ops therefore have one IDLE cycle between DONE and the next CALC.
- Reset asserted mid-CALC: immediate return to the reset values above; no result_valid.

Test Plan:
- MUL 7*(-3) (data1=7, data2=0xFFFFFFFD, funct3=0) -> stall high in cycles 0-32; result_valid only in cycle 33; result=0xFFFFFFEB.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> result=0xFFFFFFFE. MULHSU 0xFFFFFFFF*2 -> result=0xFFFFFFFF.
- DIV -7/2 -> result=0xFFFFFFFD. REM -7/2 -> result=0xFFFFFFFF. DIVU 100/7 -> result=14.
- DIVU 5/0 -> result_valid in cycle 1, result=0xFFFFFFFF. REM 0x80000000/0xFFFFFFFF -> cycle 1, result=0.
- DIV started, flush at cycle 10 -> IDLE at cycle 11, no result_valid pulse, result unchanged. Then a new MUL 3*4 is accepted and returns 12.
- reset_n low at cycle 15 of a MUL -> busy, stall (start=0) and result_valid go to 0 immediately. After release, MUL 2*2 returns 4 at cycle 33.
